nibble_serial_adder: RTL and testbench



---
 rtl/nibble_add_pkg.sv | 13 +
 rtl/four_bit_adder.sv | 16 +
 rtl/nibble_serial_adder.sv | 138 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nibble_add_pkg;

    localparam int NIB_W = 4;

    // Encoding 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit adder with carry-in/carry-out; the nibble datapath of the serial adder.
module four_bit_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] total;

    assign total = {1'b0, x} + {1'b0, y} + {4'b0, c_in};
    assign sum   = total[3:0];
    assign c_out = total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one four_bit_adder, LSB nibble first, with the carry registered
// between nibbles. Operands in and result out over valid/ready handshakes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready high, waiting for operands
// ADD     | one nibble per cycle through four_bit_adder, idx = current nibble
// DONE    | out_valid high, result held until out_ready
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t state;
    state_t state_nxt;

    logic [NIB-1:0][NIB_W-1:0] a_reg;
    logic [NIB-1:0][NIB_W-1:0] b_reg;
    logic [NIB-1:0][NIB_W-1:0] sum_reg;
    logic [NIB-1:0][NIB_W-1:0] sum_next;
    logic                      carry_reg;
    logic [IDX_W-1:0]          idx;

    logic [NIB_W-1:0] nib_sum;
    logic             nib_c_out;
    logic             accept;
    logic             last;
    logic             ovf_final;

    assign accept = (state == ST_IDLE) && in_valid;
    assign last   = (state == ST_ADD) && (idx == IDX_LAST);

    four_bit_adder u_nib_add (
        .x     (a_reg[idx]),
        .y     (b_reg[idx]),
        .c_in  (carry_reg),
        .sum   (nib_sum),
        .c_out (nib_c_out)
    );

    // Working sum with the current nibble merged in, so completion can publish it directly.
    always_comb begin
        sum_next      = sum_reg;
        sum_next[idx] = nib_sum;
    end

    assign ovf_final = (a_reg[NIB-1][NIB_W-1] == b_reg[NIB-1][NIB_W-1]) &&
                       (nib_sum[NIB_W-1] != a_reg[NIB-1][NIB_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = in_valid  ? ST_ADD  : ST_IDLE;
            ST_ADD:  state_nxt = last      ? ST_DONE : ST_ADD;
            ST_DONE: state_nxt = out_ready ? ST_IDLE : ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_ADD:  busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Published result lives apart from sum_reg so it persists while the next add runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= c_in;
            sum_reg   <= '0;
            idx       <= '0;
        end else if (state == ST_ADD) begin
            sum_reg   <= sum_next;
            carry_reg <= nib_c_out;
            if (last) begin
                sum      <= sum_next;
                c_out    <= nib_c_out;
                overflow <= ovf_final;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: 16-bit and 4-bit instances checked against an arithmetic model.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv16, ir16, ov16, or16, ci16, co16, of16, bz16;
    logic [15:0] a16, b16, s16;

    logic        iv4, ir4, ov4, or4, ci4, co4, of4, bz4;
    logic [3:0]  a4, b4, s4;

    int n_chk  = 0;
    int n_fail = 0;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .c_in(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .c_out(co16),
        .overflow(of16), .busy(bz16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .c_in(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .c_out(co4),
        .overflow(of4), .busy(bz4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum for sum/carry, true signed sum for overflow.
    task automatic ref_add(input int w, input int x, input int y, input int ci,
                           output int es, output int ec, output int eo);
        int u, sx, sy, s;
        u  = x + y + ci;
        es = u & ((1 << w) - 1);
        ec = (u >> w) & 1;
        sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
        sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
        s  = sx + sy + ci;
        eo = (s >= (1 << (w - 1)) || s < -(1 << (w - 1))) ? 1 : 0;
    endtask

    task automatic start16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int k = 0;
        while (!ir16 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready16_before_accept", ir16, 1);
        a16 = x; b16 = y; ci16 = ci; iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        check("busy16_after_accept", bz16, 1);
        check("in_ready16_after_accept", ir16, 0);
    endtask

    // Called at the first negedge after the accepting edge.
    task automatic wait_res16(input logic [15:0] x, input logic [15:0] y, input logic ci,
                              input bit noise);
        int k = 0;
        int es, ec, eo;
        ref_add(16, int'(x), int'(y), int'(ci), es, ec, eo);
        while (!ov16 && k < 20) begin
            if (noise) begin
                iv16 = 1'($urandom_range(1));
                a16  = 16'($urandom);
                b16  = 16'($urandom);
            end
            @(negedge clk);
            k++;
        end
        iv16 = 1'b0;
        check("latency16", k, 4);
        check("sum16", s16, es);
        check("c_out16", co16, ec);
        check("overflow16", of16, eo);
        check("in_ready16_in_done", ir16, 0);
    endtask

    task automatic release16(input logic [15:0] es);
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("out_valid16_after_release", ov16, 0);
        check("in_ready16_after_release", ir16, 1);
        check("sum16_persist", s16, es);
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic ci, input bit noise);
        int es, ec, eo;
        ref_add(16, int'(x), int'(y), int'(ci), es, ec, eo);
        start16(x, y, ci);
        wait_res16(x, y, ci, noise);
        release16(16'(es));
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int k = 0;
        int es, ec, eo;
        ref_add(4, int'(x), int'(y), int'(ci), es, ec, eo);
        check("in_ready4_before_accept", ir4, 1);
        a4 = x; b4 = y; ci4 = ci; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        while (!ov4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency4", k, 1);
        check("sum4", s4, es);
        check("c_out4", co4, ec);
        check("overflow4", of4, eo);
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        check("in_ready4_after_release", ir4, 1);
    endtask

    initial begin
        logic [15:0] hold_sum;
        rst = 1'b1;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; ci16 = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; ci4 = 0;
        #1;
        check("reset_in_ready", ir16, 1);
        check("reset_out_valid", ov16, 0);
        check("reset_sum", s16, 0);
        check("reset_busy", bz16, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op16(16'hFFFF, 16'h0001, 1'b0, 0);
        op16(16'h7FFF, 16'h0001, 1'b0, 0);
        op16(16'h8000, 16'h8000, 1'b0, 0);
        op16(16'h1234, 16'h4321, 1'b1, 1);

        // Backpressure with a pending request held on the input side.
        start16(16'h1111, 16'h2222, 1'b0);
        wait_res16(16'h1111, 16'h2222, 1'b0, 0);
        hold_sum = 16'h3333;
        a16 = 16'h0F0F; b16 = 16'h00F1; ci16 = 1'b0; iv16 = 1'b1; or16 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", ov16, 1);
            check("bp_sum_hold", s16, hold_sum);
            check("bp_in_ready", ir16, 0);
        end
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("bp_idle_in_ready", ir16, 1);
        check("bp_idle_out_valid", ov16, 0);
        @(negedge clk);
        iv16 = 1'b0;
        check("bp_pending_accepted", bz16, 1);
        wait_res16(16'h0F0F, 16'h00F1, 1'b0, 0);
        release16(16'h1000);

        // Reset two cycles into ADD.
        start16(16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", ov16, 0);
        check("rst_mid_sum", s16, 0);
        check("rst_mid_c_out", co16, 0);
        check("rst_mid_overflow", of16, 0);
        check("rst_mid_busy", bz16, 0);
        check("rst_mid_in_ready", ir16, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op16(16'h0003, 16'h0004, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        op4(4'hF, 4'h1, 1'b1);
        op4(4'h7, 4'h1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
